dmem_responder: RTL and testbench

//   Multi-cycle data-memory responder for the pipelined core's MEM stage. Accepts one

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one valid/ready request in flight, fixed latency, byte-lane stores.
// Optional macro DMEM_MISALIGN_ERR_EN: reject accesses whose addr[1:0] != 0 with resp_err_o.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             commit_c;
  logic             release_c;
  logic             range_err_c;
  logic             err_c;
  logic [IDX_W-1:0] mem_idx;

  logic [31:0] mem [DEPTH_WORDS];

  // Word index of the latched request and its rejection conditions
  assign mem_idx     = req_q.addr[IDX_W+1:2];
  assign range_err_c = 32'(req_q.addr[31:2]) >= 32'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_ERR_EN
  assign err_c = range_err_c | (req_q.addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_q.addr[1:0];
  assign err_c = range_err_c;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    commit_c  = 1'b0;
    release_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          req_d   = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          release_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered handshake/response outputs; response held until taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      req_ready_o <= (state_d == S_IDLE);
      if (commit_c) begin
        resp_valid_o <= 1'b1;
        resp_err_o   <= err_c;
        resp_rdata_o <= (err_c || req_q.we) ? 32'h0 : mem[mem_idx];
      end else if (release_c) begin
        resp_valid_o <= 1'b0;
        resp_err_o   <= 1'b0;
        resp_rdata_o <= '0;
      end
    end
  end

  // Array is not reset; writes happen only on a committed, accepted store
  always_ff @(posedge clk_i) begin
    if (commit_c && req_q.we && !err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (req_q.be[k]) mem[mem_idx][8*k +: 8] <= req_q.wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset mid-op, latency, byte enables, backpressure, range, misalign.
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o  (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count edges after an accept until resp_valid_o is seen (bounded)
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk_i);
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    check({tag, "_valid_clr"}, 32'(resp_valid_o), 32'd0);
    check({tag, "_ready_ret"}, 32'(req_ready_o), 32'd1);
  endtask

  // Full transaction: issue, check latency and response, then take it
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int guard;
    @(negedge clk_i);
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_wdata_i = 32'hFFFF_FFFF;
    req_be_i    = 4'hF;
    wait_resp(n);
    check({tag, "_lat"}, 32'(n), 32'd2);
    check({tag, "_rdata"}, resp_rdata_o, exp_rdata);
    check({tag, "_err"}, 32'(resp_err_o), 32'(exp_err));
    handshake(tag);
  endtask

  initial begin
    int n;
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_be_i     = '0;
    resp_ready_i = 1'b0;
    #12;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_err", 32'(resp_err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset during WAIT drops the pending store
    txn("pre10", 1'b1, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10;
    req_wdata_i = 32'hDEAD_BEEF; req_be_i = 4'hF;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready_o), 32'd1);
    check("mid_rst_valid", 32'(resp_valid_o), 32'd0);
    check("mid_rst_rdata", resp_rdata_o, 32'd0);
    check("mid_rst_err", 32'(resp_err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    check("mid_rst_noresp", 32'(resp_valid_o), 32'd0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    // Roundtrip and byte enables
    txn("st40", 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    txn("ld40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    txn("st40_be", 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    txn("ld40_be", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);
    txn("st40_be0", 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    txn("ld40_be0", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);

    // Backpressure with req_valid_i held high; second request's inputs change after accept
    @(negedge clk_i);
    check("bp_ready0", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h40; req_be_i = 4'h0;
    @(posedge clk_i); #1;
    req_addr_i = 32'h10;
    wait_resp(n);
    check("bp_lat", 32'(n), 32'd2);
    check("bp_rdata", resp_rdata_o, 32'h12BB_56DD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("bp_hold_valid", 32'(resp_valid_o), 32'd1);
      check("bp_hold_rdata", resp_rdata_o, 32'h12BB_56DD);
      check("bp_hold_ready", 32'(req_ready_o), 32'd0);
    end
    @(negedge clk_i);
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    check("bp_hs_valid", 32'(resp_valid_o), 32'd0);
    check("bp_hs_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    check("bp_next_accept", 32'(req_ready_o), 32'd0);
    req_valid_i = 1'b0;
    req_addr_i  = 32'h40;
    wait_resp(n);
    check("bp_next_lat", 32'(n), 32'd2);
    check("bp_next_rdata", resp_rdata_o, 32'h0);
    handshake("bp_next");

    // Range: idx 1024 rejected, neighbours and aliased word 0 untouched
    txn("st0", 1'b1, 32'h0, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
    txn("stffc", 1'b1, 32'h0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    txn("st1000", 1'b1, 32'h1000, 32'h1111_1111, 4'hF, 32'h0, 1'b1);
    txn("ld1000", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("ldffc", 1'b0, 32'h0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    txn("ld0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0);

    // Misaligned load
`ifdef DMEM_MISALIGN_ERR_EN
    txn("ld42", 1'b0, 32'h42, 32'h0, 4'h0, 32'h0, 1'b1);
`else
    txn("ld42", 1'b0, 32'h42, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
